ultrasonic_scheduler: RTL
=========================

Name: ultrasonic_scheduler

Overview:
Time-multiplexes up to NUM_SENSORS HC-SR04 ultrasonic sensors so that only one is active at a time, which prevents acoustic crosstalk between them. For each enabled sensor in round-robin order it generates the trigger pulse, times the echo and converts the echo width to millimetres. It also applies a timeout and holds a per-sensor distance and obstacle flag. It sits between the sensor pins and the navigation/obstacle-avoidance logic.

Parameters:
NUM_SENSORS, 3, number of sensor channels (1..4).
TRIG_CYCLES, 500, trigger high width in clk_50M cycles (10 us).
TIMEOUT_CYCLES, 600000, maximum wait for echo rise, and maximum echo high width (12 ms).
GAP_CYCLES, 100000, settle time after each measurement before the next trigger (2 ms).
OBST_MM, 70, obstacle threshold in mm.

Ports:
clk_50M  input  1  50 MHz clock
reset  input  1  synchronous, active-low reset
enable_mask  input  NUM_SENSORS  1 = channel participates in the rotation
echo_rx  input  NUM_SENSORS  raw echo pins, asynchronous
trig  output  NUM_SENSORS  trigger pins; at most one bit high at any time
dist_flat  output  16*NUM_SENSORS  distance in mm per channel; channel i occupies bits [16i+15:16i]
present  output  NUM_SENSORS  1 = channel distance <= OBST_MM and last measurement not timed out
timeout_flag  output  NUM_SENSORS  1 = channel's last measurement timed out
meas_valid  output  1  single-cycle pulse when a channel's result is updated
meas_idx  output  2  channel index qualified by meas_valid

Behaviour:
- Reset (reset=0 sampled at a clk_50M edge) applies on that edge, including mid-measurement:
  - trig=0, dist_flat=0, present=0, timeout_flag=0, meas_valid=0, meas_idx=0.
  - State goes to SELECT.
  - Round-robin pointer = NUM_SENSORS-1, so channel 0 is served first.
- echo_rx passes through a 2-flop synchronizer per bit; only the selected channel's synchronized echo is examined.
- A single 20-bit cycle counter is shared by all states and cleared on every state transition.
- SELECT:
  - If enable_mask==0, remain in SELECT with all trig low.
  - Otherwise choose the first enabled channel strictly after the pointer, wrapping; update the pointer and go to TRIG.
- TRIG: trig[sel]=1 for exactly TRIG_CYCLES cycles, then trig[sel]=0 and go to WAIT_RISE.
- WAIT_RISE:
  - On a synchronized echo rise, go to MEASURE with echo count = 0.
  - If the counter reaches TIMEOUT_CYCLES first, perform TIMEOUT.
- MEASURE:
  - Increment the echo count each cycle while echo is high.
  - On echo low, compute distance = (echo_count*34)/10000 using a 26-bit intermediate, then truncate to 16 bits.
  - Write distance to channel sel, set timeout_flag[sel]=0 and present[sel]=(distance<=OBST_MM), then go to GAP.
  - If the echo count reaches TIMEOUT_CYCLES while echo is still high, perform TIMEOUT.
- TIMEOUT action: dist[sel]=16'hFFFF, present[sel]=0, timeout_flag[sel]=1, then go to GAP.
- Every result update (normal or TIMEOUT) asserts meas_valid=1 for exactly one cycle, on the cycle the registers update, with meas_idx=sel.
- GAP: wait GAP_CYCLES cycles, then go to SELECT.
- enable_mask changes mid-measurement do not abort the current channel; the new mask takes effect at the next SELECT.
- Disabled channels keep their last dist/present/timeout values.
- Echo activity on non-selected channels is ignored.
- Echo already high on entry to WAIT_RISE does not count as a rise; a low-to-high transition is required.

Test Plan:
- enable_mask=3'b111, echo width 100000 cycles on every channel -> trig pulses of 500 cycles in order ch0, ch1, ch2, ch0…; each dist=340; present=0; meas_valid pulses with meas_idx 0,1,2.
- ch1 echo width 20000 cycles -> dist[1]=68, present[1]=1; width 20900 cycles -> dist[1]=71, present[1]=0.
- ch2 echo never rises -> 600000 cycles after trig falls: dist[2]=FFFF, timeout_flag[2]=1, present[2]=0; rotation continues to ch0.
- enable_mask=3'b101 -> service order ch0, ch2, ch0; trig[1] never asserts; mask=0 -> all trig stay 0 indefinitely, no meas_valid.
- Assert reset for one cycle during MEASURE on ch1 -> next cycle all outputs are 0 and state is SELECT; after release, the first trig is on ch0.
- Echo held high beyond 600000 cycles on ch0 -> timeout result on ch0; trig never overlaps across channels (assert onehot0(trig) every cycle).

Source files
------------

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for HC-SR04 ultrasonic sensors: one channel is triggered
// and timed at a time, and each result is held as a distance, obstacle flag and timeout flag.
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS    = 3,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 600000,
  parameter int GAP_CYCLES     = 100000,
  parameter int OBST_MM        = 70
) (
  input  logic                      clk_50M,
  input  logic                      reset,
  input  logic [NUM_SENSORS-1:0]    enable_mask,
  input  logic [NUM_SENSORS-1:0]    echo_rx,
  output logic [NUM_SENSORS-1:0]    trig,
  output logic [16*NUM_SENSORS-1:0] dist_flat,
  output logic [NUM_SENSORS-1:0]    present,
  output logic [NUM_SENSORS-1:0]    timeout_flag,
  output logic                      meas_valid,
  output logic [1:0]                meas_idx
);

  typedef enum logic [2:0] {
    SELECT,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  localparam logic [19:0] TRIG_LAST    = 20'(TRIG_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] GAP_LAST     = 20'(GAP_CYCLES - 1);
  localparam logic [15:0] OBST_LIMIT   = 16'(OBST_MM);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [19:0]             r_count;
  logic [1:0]              r_sel;
  logic [1:0]              w_nextSel;
  logic                    w_anyEnabled;
  logic [NUM_SENSORS-1:0]  r_echoMeta;
  logic [NUM_SENSORS-1:0]  r_echoSync;
  logic                    r_echoPrev;
  logic                    w_echoSel;
  logic                    w_echoRise;
  logic                    w_doResult;
  logic                    w_doTimeout;
  logic [15:0]             r_dist [NUM_SENSORS];
  logic [19:0]             w_echoWidth;
  logic [25:0]             w_product;
  logic [25:0]             w_quotient;
  logic [15:0]             w_dist;

  assign w_anyEnabled = |enable_mask;
  assign w_echoSel    = r_echoSync[r_sel];
  assign w_echoRise   = w_echoSel & ~r_echoPrev;

  // The rise cycle itself was already a high sample, so it is included in the width.
  assign w_echoWidth = r_count + 20'd1;
  assign w_product   = 26'(w_echoWidth) * 26'd34;
  assign w_quotient  = w_product / 26'd10000;
  assign w_dist      = w_quotient[15:0];

  always_comb begin
    int idx;
    logic found;
    w_nextSel = r_sel;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_SENSORS; off++) begin
      idx = int'(r_sel) + off;
      if (idx >= NUM_SENSORS) idx = idx - NUM_SENSORS;
      if (!found && enable_mask[idx]) begin
        found     = 1'b1;
        w_nextSel = 2'(idx);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_doResult  = 1'b0;
    w_doTimeout = 1'b0;
    trig        = '0;
    case (r_state)
      SELECT: begin
        if (w_anyEnabled) w_nextState = TRIG;
      end
      TRIG: begin
        trig[r_sel] = 1'b1;
        if (r_count == TRIG_LAST) w_nextState = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_echoRise) begin
          w_nextState = MEASURE;
        end else if (r_count == TIMEOUT_LAST) begin
          w_doTimeout = 1'b1;
          w_nextState = GAP;
        end
      end
      MEASURE: begin
        if (!w_echoSel) begin
          w_doResult  = 1'b1;
          w_nextState = GAP;
        end else if (r_count == TIMEOUT_LAST) begin
          w_doTimeout = 1'b1;
          w_nextState = GAP;
        end
      end
      GAP: begin
        if (r_count == GAP_LAST) w_nextState = SELECT;
      end
      default: w_nextState = SELECT;
    endcase
  end

  // The counter restarts on every state change so each state times itself from zero.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      r_state      <= SELECT;
      r_count      <= '0;
      r_sel        <= 2'(NUM_SENSORS - 1);
      r_echoMeta   <= '0;
      r_echoSync   <= '0;
      r_echoPrev   <= 1'b0;
      present      <= '0;
      timeout_flag <= '0;
      meas_valid   <= 1'b0;
      meas_idx     <= 2'd0;
      for (int i = 0; i < NUM_SENSORS; i++) r_dist[i] <= 16'd0;
    end else begin
      r_echoMeta <= echo_rx;
      r_echoSync <= r_echoMeta;
      r_echoPrev <= w_echoSel;
      r_state    <= w_nextState;
      r_count    <= (w_nextState != r_state) ? 20'd0 : r_count + 20'd1;
      if (r_state == SELECT && w_anyEnabled) r_sel <= w_nextSel;
      meas_valid <= w_doResult | w_doTimeout;
      if (w_doResult) begin
        r_dist[r_sel]       <= w_dist;
        present[r_sel]      <= (w_dist <= OBST_LIMIT);
        timeout_flag[r_sel] <= 1'b0;
        meas_idx            <= r_sel;
      end else if (w_doTimeout) begin
        r_dist[r_sel]       <= 16'hFFFF;
        present[r_sel]      <= 1'b0;
        timeout_flag[r_sel] <= 1'b1;
        meas_idx            <= r_sel;
      end
    end
  end

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_distFlat
    assign dist_flat[16*g +: 16] = r_dist[g];
  end

endmodule
